prestore_multi: RTL
===================

// Module: prestore_multi
// PURPOSE
//  N_CH-channel complex pre-accumulator for the acquisition path. Per lane
//  (I/Q per channel) it sums 2-bit sig/mag samples over a bin set by an
//  internal phase accumulator, then requantises each sum back to sig/mag.
//  Start is immediate or synchronous to ms_epoch plus a programmable delay.
//  Sits between the front-end sig/mag quantisers and the correlator/FFT search.
// PARAMETERS
//  N_CH     2   complex channels; lanes = 2*N_CH (lane 2c = I[c], 2c+1 = Q[c])
//  ACC_W    16  signed lane accumulator width, saturating
//  PHASE_W  32  bin phase accumulator width
//  DELAY_W  32  start-delay counter width
// PORTS
//  clk        in   1          sample clock
//  resetn     in   1          asynchronous, active-low reset
//  in_valid   in   1          sample strobe; all lanes sampled together
//  sig_i      in   N_CH       I sign per channel (1 = negative)
//  mag_i      in   N_CH       I magnitude per channel (1 = large)
//  sig_q      in   N_CH       Q sign per channel
//  mag_q      in   N_CH       Q magnitude per channel
//  ms_epoch   in   1          1-cycle epoch pulse for synchronous start
//  cfg_start  in   1          1-cycle start request
//  cfg_stop   in   1          1-cycle stop request (wins over cfg_start)
//  cfg_sync   in   1          1 = arm and wait for ms_epoch, 0 = start now
//  cfg_delay  in   DELAY_W    cycles from epoch to RUN
//  cfg_step   in   PHASE_W    phase increment per valid sample
//  cfg_thr    in   ACC_W-1    magnitude threshold for requantisation
//  out_sig    out  2*N_CH     requantised sign per lane
//  out_mag    out  2*N_CH     requantised magnitude per lane
//  out_valid  out  1          1-cycle strobe: bin result ready
//  busy       out  1          state != IDLE
//  bin_cnt    out  32         bins emitted since last start, wraps at 2^32
// BEHAVIOUR
//  Reset: state IDLE, all accumulators/phase/counters 0, out_* 0, busy 0.
//  Sample value: sig=0/mag=0 -> +1, 0/1 -> +3, 1/0 -> -1, 1/1 -> -3.
//  FSM: IDLE -(start & !sync)-> RUN; IDLE -(start & sync)-> ARMED;
//   ARMED -(ms_epoch)-> DELAY (cnt<=cfg_delay); DELAY decrements each clk,
//   -> RUN when cnt==0 (delay 0 => RUN the cycle after epoch).
//   Epoch pulses in DELAY/RUN ignored. start outside IDLE ignored.
//   stop in any state -> IDLE next cycle; partial bin discarded, no out_valid.
//  Entering RUN: phase, accumulators, bin_cnt cleared.
//  RUN, in_valid=1: {carry,phase} <= phase + cfg_step. carry=0: each lane
//   acc <= sat(acc + v). carry=1 (bin end): sample v closes the bin:
//   result = sat(acc + v) latched, acc <= 0; out_valid next cycle.
//  Latency: out_valid 1 clk after the bin-closing sample; outputs hold
//   until next bin. bin_cnt increments with out_valid.
//  Requantise: out_sig = result<0; out_mag = |result| >= cfg_thr.
//  Saturation: clamp to +/-(2^(ACC_W-1)-1), symmetric.
//  cfg_step = 0: no bin ever closes; accumulators saturate, no output.
//  cfg_* sampled live; change only while IDLE (else undefined bin length).
//  in_valid=0 in RUN: phase and accumulators hold.
// CONFIGURATION
//  PRESTORE_SUM_OUT_EN defined: extra outputs out_sum [2*N_CH*ACC_W] (lane
//   results, lane 0 in LSBs, valid with out_valid) and sat_flag [2*N_CH]
//   (set if lane saturated in that bin, updated with out_valid).
//  Not defined: ports absent, no saturation flag logic; rest identical.
// TESTING
//  step=2^30, sync=0, all lanes sig=0 mag=1, thr=8 -> out_valid every 4
//   samples, result +12, out_sig=0 out_mag=1 all lanes, bin_cnt 1,2,3...
//  step=2^30, lanes alternate +1/-1 per sample, thr=1 -> result 0,
//   out_sig=0 out_mag=0.
//  sync=1, delay=10, epoch at t0 -> busy at start, RUN at t0+11, first
//   out_valid exactly 4 valid samples later; second epoch has no effect.
//  ACC_W=4, step=2^28 (16 samples), all -3 -> result clamps -7, sig=1;
//   with PRESTORE_SUM_OUT_EN sat_flag all 1, out_sum lanes = -7.
//  stop 2 samples into a bin -> no out_valid, busy=0 next clk; restart ->
//   bin_cnt restarts at 1, first bin full length.
//  resetn low mid-RUN -> all outputs 0 immediately; after release IDLE,
//   no out_valid until new cfg_start.

Source files
------------

// File: rtl/prestore_multi.sv
// rtl/prestore_multi.sv - N_CH complex sig/mag pre-accumulator with phase-set bins
// Define PRESTORE_SUM_OUT_EN to expose raw lane sums (out_sum) and per-bin saturation flags (sat_flag).
module prestore_multi #(
    parameter int N_CH    = 2,
    parameter int ACC_W   = 16,
    parameter int PHASE_W = 32,
    parameter int DELAY_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [N_CH-1:0]          sig_i,
    input  logic [N_CH-1:0]          mag_i,
    input  logic [N_CH-1:0]          sig_q,
    input  logic [N_CH-1:0]          mag_q,
    input  logic                     ms_epoch,
    input  logic                     cfg_start,
    input  logic                     cfg_stop,
    input  logic                     cfg_sync,
    input  logic [DELAY_W-1:0]       cfg_delay,
    input  logic [PHASE_W-1:0]       cfg_step,
    input  logic [ACC_W-2:0]         cfg_thr,
    output logic [2*N_CH-1:0]        out_sig,
    output logic [2*N_CH-1:0]        out_mag,
    output logic                     out_valid,
    output logic                     busy,
    output logic [31:0]              bin_cnt
`ifdef PRESTORE_SUM_OUT_EN
    ,
    output logic [2*N_CH*ACC_W-1:0]  out_sum,
    output logic [2*N_CH-1:0]        sat_flag
`endif
);

    localparam int LANES = 2 * N_CH;
    localparam logic signed [ACC_W:0] MAXV = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] V1   = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] V3   = (ACC_W+1)'(3);
    localparam logic [DELAY_W-1:0]    ONE_D = DELAY_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DELAY, S_RUN} state_t;

    state_t               state_q, state_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 carry;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic [LANES-1:0]     out_sig_q, out_mag_q;
    logic                 out_valid_q;
    logic [31:0]          bin_cnt_q;

    logic [LANES-1:0]     lane_sig, lane_mag;
    logic signed [ACC_W:0] sum_full [LANES];
    logic signed [ACC_W:0] sat_full [LANES];
    logic signed [ACC_W:0] abs_full [LANES];
    logic [LANES-1:0]     clamp, res_sig, res_mag;
    logic                 enter_run, advance;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) state_d = cfg_sync ? S_ARMED : S_RUN;
            end
            S_ARMED: begin
                if (ms_epoch) begin
                    if (cfg_delay == '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = cfg_delay;
                    end
                end
            end
            S_DELAY: begin
                // RUN lands cfg_delay cycles after the cycle following the epoch
                cnt_d = cnt_q - ONE_D;
                if (cnt_q <= ONE_D) state_d = S_RUN;
            end
            default: ;
        endcase
        if (cfg_stop) state_d = S_IDLE;
    end

    assign enter_run = (state_d == S_RUN) && (state_q != S_RUN);
    assign advance   = (state_q == S_RUN) && !cfg_stop && in_valid;
    assign {carry, phase_d} = {1'b0, phase_q} + {1'b0, cfg_step};

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            lane_sig[2*c]   = sig_i[c];
            lane_mag[2*c]   = mag_i[c];
            lane_sig[2*c+1] = sig_q[c];
            lane_mag[2*c+1] = mag_q[c];
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sum_full[l] = $signed({acc_q[l][ACC_W-1], acc_q[l]})
                        + (lane_sig[l] ? (lane_mag[l] ? -V3 : -V1) : (lane_mag[l] ? V3 : V1));
            clamp[l] = 1'b0;
            sat_full[l] = sum_full[l];
            if (sum_full[l] > MAXV) begin
                sat_full[l] = MAXV;
                clamp[l]    = 1'b1;
            end else if (sum_full[l] < -MAXV) begin
                sat_full[l] = -MAXV;
                clamp[l]    = 1'b1;
            end
            res_sig[l]  = sat_full[l][ACC_W];
            abs_full[l] = res_sig[l] ? -sat_full[l] : sat_full[l];
            res_mag[l]  = $unsigned(abs_full[l]) >= {2'b00, cfg_thr};
        end
    end

`ifdef PRESTORE_SUM_OUT_EN
    logic [LANES*ACC_W-1:0] out_sum_q;
    logic [LANES-1:0]       sat_flag_q, sat_seen_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_sum_q  <= '0;
            sat_flag_q <= '0;
            sat_seen_q <= '0;
        end else if (enter_run) begin
            sat_seen_q <= '0;
        end else if (advance) begin
            if (carry) begin
                sat_seen_q <= '0;
                sat_flag_q <= sat_seen_q | clamp;
                for (int l = 0; l < LANES; l++) begin
                    out_sum_q[l*ACC_W +: ACC_W] <= sat_full[l][ACC_W-1:0];
                end
            end else begin
                sat_seen_q <= sat_seen_q | clamp;
            end
        end
    end

    assign out_sum  = out_sum_q;
    assign sat_flag = sat_flag_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            out_sig_q   <= '0;
            out_mag_q   <= '0;
            out_valid_q <= 1'b0;
            bin_cnt_q   <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= 1'b0;
            if (enter_run) begin
                phase_q   <= '0;
                bin_cnt_q <= '0;
                for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
            end else if (advance) begin
                phase_q <= phase_d;
                if (carry) begin
                    // the carry sample is folded into the closing result
                    out_sig_q   <= res_sig;
                    out_mag_q   <= res_mag;
                    out_valid_q <= 1'b1;
                    bin_cnt_q   <= bin_cnt_q + 32'd1;
                    for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
                end else begin
                    for (int l = 0; l < LANES; l++) acc_q[l] <= sat_full[l][ACC_W-1:0];
                end
            end
        end
    end

    assign out_sig   = out_sig_q;
    assign out_mag   = out_mag_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign bin_cnt   = bin_cnt_q;

endmodule
